alu_req_arbiter: RTL
====================

# alu_req_arbiter

Two-port round-robin arbiter and sequencer that shares the single 8-bit ALU (Control_Unit plus datapath) between two requesters. Each requester submits an op code and two operands. The block grants one requester, latches its request, and pulses the ALU start. It then waits for the ALU end pulse, or a timeout, and returns the 16-bit result on a shared response bus tagged with the requester id. It sits between the system front-end and the ALU's begin/end handshake.

## Interface
- `WIDTH`, 8, operand width; result is 2*WIDTH bits
- `TIMEOUT`, 64, maximum WAIT cycles before an operation is declared failed (must be >=2)
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req0_valid` / `req1_valid` in 1: request pending
- `req0_op` / `req1_op` in 3: ALU op code; 3'b111 is reserved
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in WIDTH: operands
- `req0_ready` / `req1_ready` out 1: accept strobe; transfer occurs when valid&&ready
- `alu_begin` out 1: one-cycle start pulse to the ALU (drives begin_signal)
- `alu_op` out 3, `alu_a` out WIDTH, `alu_b` out WIDTH: held stable from ISSUE through RESP
- `alu_end` in 1: ALU completion (end_signal)
- `alu_result` in 2*WIDTH: ALU result, valid while alu_end=1
- `alu_abort` out 1: one-cycle pulse on timeout, used to clear the ALU control unit
- `rsp_valid` out 1: one-cycle response strobe
- `rsp_id` out 1: requester served (0/1)
- `rsp_result` out 2*WIDTH: captured result; 0 on error
- `rsp_err` out 1: timeout or reserved op
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset -> IDLE.
- `prio` register (reset 0) selects the preferred requester on conflict. After any RESP for requester N, `prio` becomes ~N.
- IDLE arbitration:
  - If exactly one valid, grant it.
  - If both are valid, grant `prio`.
  - `reqN_ready` = (state==IDLE) && grantN, which is combinational, and at most one is high.
  - On accept, latch op/a/b/id.
  - Reserved op 3'b111 goes to RESP with err=1, with no ALU activity.
  - Any other op goes to ISSUE.
- ISSUE: `alu_begin`=1 for exactly this cycle, and alu_op/a/b present the latched values. Go to WAIT. `alu_end` is ignored in ISSUE.
- WAIT:
  - Counter starts at 0 on the first WAIT cycle and increments every cycle.
  - If `alu_end`=1, capture `alu_result` and go to RESP with err=0.
  - Otherwise, if counter==TIMEOUT-1, pulse `alu_abort` and go to RESP with err=1 and result 0.
  - If `alu_end` arrives on the same cycle as the timeout, success wins.
- RESP: `rsp_valid`=1 for one cycle with id/result/err, update `prio`, return to IDLE. There is no backpressure on the response bus.
- Requester inputs are not sampled outside the IDLE accept cycle. A requester dropping valid before its grant is legal.
- Counter width is clog2(TIMEOUT). The counter never wraps because it is cleared on entry to WAIT.

## Timing
- Reset values:
  - All outputs are 0: ready, alu_begin, alu_op/a/b, alu_abort, rsp_valid, rsp_id, rsp_result, rsp_err, busy.
  - state=IDLE, prio=0, counter=0.
- Accept at cycle T: `alu_begin` at T+1. WAIT starts at T+2.
- `alu_end` at cycle T+k (k>=2): `rsp_valid` at T+k+1. The earliest next accept is T+k+2, so the minimum turnaround is 4 cycles per operation.
- Reserved op accepted at T: `rsp_valid`/`rsp_err` at T+1, next accept at T+2.
- Timeout: `alu_abort` is pulsed in the last WAIT cycle, T+1+TIMEOUT. The err response follows at T+2+TIMEOUT.
- Reset asserted in any state: on the next edge, state goes to IDLE, all outputs go to their reset values, and prio goes to 0. An in-flight operation is dropped without a response.

## Test plan
- Single request: req0 op=3'b000, a=8'hF0, b=8'h3C. ALU model returns 16'h0030 with `alu_end` 3 cycles after begin. Expected: `req0_ready` at T, `alu_begin` at T+1, rsp at T+5 with id=0, result=16'h0030, err=0.
- Simultaneous requests from both ports, repeated 4 times back-to-back. Expected grant order 0,1,0,1, and `alu_begin` never overlaps an active WAIT.
- Timeout with TIMEOUT=8 and `alu_end` never asserted. Expected: `alu_abort` at T+9, rsp at T+10 with err=1 and result=0, and `prio` flips.
- Reserved op 3'b111 on req1. Expected: rsp at T+1 with id=1, err=1, no `alu_begin`, no `alu_abort`.
- `alu_end` asserted during ISSUE, then again at WAIT cycle 2. Expected: the first pulse is ignored and the result is captured from the second.
- Reset asserted in WAIT. Expected: next cycle busy=0, all outputs 0, and no `rsp_valid`. A following simultaneous request grants req0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-port round-robin arbiter and sequencer for a shared
// 8-bit ALU. It grants one requester, latches its op/operands, pulses
// alu_begin, waits for alu_end (or a timeout), then returns a tagged result.
//
// Ports:
//   clk, reset               : rising-edge clock, synchronous active-high reset
//   reqN_valid/op/a/b        : requester N command (op 3'b111 is reserved)
//   reqN_ready               : combinational accept strobe (IDLE only)
//   alu_begin                : one-cycle start pulse to the ALU
//   alu_op/alu_a/alu_b       : latched command, held from ISSUE through RESP
//   alu_end/alu_result       : ALU completion and result
//   alu_abort                : one-cycle pulse in the last WAIT cycle on timeout
//   rsp_valid/id/result/err  : one-cycle response strobe
//   busy                     : FSM not in IDLE
module alu_req_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [2:0]         req0_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [2:0]         req1_op,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               alu_begin,
  output logic [2:0]         alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic               alu_end,
  input  logic [2*WIDTH-1:0] alu_result,
  output logic               alu_abort,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_err,
  output logic               busy
);

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);
  localparam logic [2:0]    OP_RSVD = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic               r_prio;
  logic               r_id;
  logic [CW-1:0]      r_cnt;
  logic               r_alu_begin;
  logic [2:0]         r_alu_op;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [2*WIDTH-1:0] r_rsp_result;
  logic               r_rsp_err;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_idle;
  logic [2:0]         w_sel_op;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;

  always_comb begin
    w_grant0 = req0_valid && (!req1_valid || !r_prio);
    w_grant1 = req1_valid && (!req0_valid ||  r_prio);
    // No accept while reset is asserted: the transfer would be dropped.
    w_idle   = (r_state == S_IDLE) && !reset;
    w_sel_op = w_grant1 ? req1_op : req0_op;
    w_sel_a  = w_grant1 ? req1_a  : req0_a;
    w_sel_b  = w_grant1 ? req1_b  : req0_b;
  end

  assign req0_ready = w_idle && w_grant0;
  assign req1_ready = w_idle && w_grant1;

  // Abort is decoded from registered state so it lands in the last WAIT
  // cycle itself and can be suppressed by a same-cycle alu_end.
  assign alu_abort  = (r_state == S_WAIT) && (r_cnt == CNT_END) && !alu_end;

  assign alu_begin  = r_alu_begin;
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_prio       <= 1'b0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_alu_begin  <= 1'b0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_alu_begin <= 1'b0;
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            r_id <= w_grant1;
            if (w_sel_op == OP_RSVD) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_id     <= w_grant1;
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_state      <= S_RESP;
            end else begin
              r_alu_op    <= w_sel_op;
              r_alu_a     <= w_sel_a;
              r_alu_b     <= w_sel_b;
              r_alu_begin <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (alu_end) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= alu_result;
            r_state      <= S_RESP;
          end else if (r_cnt == CNT_END) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_err    <= 1'b1;
            r_rsp_result <= '0;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_prio       <= ~r_rsp_id;
          r_rsp_id     <= 1'b0;
          r_rsp_err    <= 1'b0;
          r_rsp_result <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
